// File: rtl/bram_asym_be.sv
`default_nettype none
// ============================================================================
// Module   : bram_asym_be
// Purpose  : Asymmetric simple-dual-port block RAM with per-byte write
//            enables, optional output register, read-valid strobe and an
//            optional post-reset zero-fill sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module bram_asym_be #(
  parameter int READ_WIDTH       = 64,
  parameter int READ_ADDR_WIDTH  = 9,
  parameter int WRITE_WIDTH      = 32,
  parameter int WRITE_ADDR_WIDTH = 10,
  parameter int OUT_REG          = 0,
  parameter int INIT_ZERO        = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          init_done,
  input  logic                          r_valid,
  input  logic [READ_ADDR_WIDTH-1:0]    r_addr,
  output logic [READ_WIDTH-1:0]         r_data,
  output logic                          r_data_valid,
  input  logic                          w_valid,
  input  logic [WRITE_ADDR_WIDTH-1:0]   w_addr,
  input  logic [WRITE_WIDTH-1:0]        w_data,
  input  logic [WRITE_WIDTH/8-1:0]      w_be
);

  // Geometry: storage is split into C_RATIO banks of narrow (C_MIN_W) words.
  // Narrow entry {A, i} lives in bank i, row A, so a wide access touches
  // every bank at the same row in a single cycle.
  localparam int C_MIN_W     = (READ_WIDTH < WRITE_WIDTH) ? READ_WIDTH : WRITE_WIDTH;
  localparam int C_MAX_W     = (READ_WIDTH < WRITE_WIDTH) ? WRITE_WIDTH : READ_WIDTH;
  localparam int C_RATIO     = C_MAX_W / C_MIN_W;
  localparam int C_LOG_R     = $clog2(C_RATIO);
  localparam int C_LANE_W    = (C_LOG_R > 0) ? C_LOG_R : 1;
  localparam int C_ROW_AW    = (READ_ADDR_WIDTH < WRITE_ADDR_WIDTH) ? READ_ADDR_WIDTH : WRITE_ADDR_WIDTH;
  localparam int C_ROWS      = 2 ** C_ROW_AW;
  localparam int C_NARROW_AW = C_ROW_AW + C_LOG_R;
  localparam int C_MAX_SIZE  = C_RATIO * C_ROWS;
  localparam int C_BPL       = C_MIN_W / 8;
  localparam bit C_RD_NARROW = (READ_WIDTH < WRITE_WIDTH);
  localparam bit C_WR_NARROW = (WRITE_WIDTH < READ_WIDTH);
  localparam int C_R_SHIFT   = C_RD_NARROW ? C_LOG_R : 0;
  localparam int C_W_SHIFT   = C_WR_NARROW ? C_LOG_R : 0;

  if (((1 << C_LOG_R) != C_RATIO) || ((C_MAX_W % C_MIN_W) != 0) ||
      ((READ_WIDTH * (2 ** READ_ADDR_WIDTH)) != (WRITE_WIDTH * (2 ** WRITE_ADDR_WIDTH))) ||
      ((WRITE_WIDTH % 8) != 0) || ((C_MIN_W % 8) != 0)) begin : g_bad_cfg
    $error("bram_asym_be: illegal width/depth combination");
  end

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [C_NARROW_AW-1:0]       r_clr_cnt;
  logic                         w_clearing;
  logic                         w_rd_acc;
  logic                         w_wr_acc;
  logic [C_ROW_AW-1:0]          w_clr_row;
  logic [C_LANE_W-1:0]          w_clr_lane;
  logic [C_ROW_AW-1:0]          w_wr_row;
  logic [C_ROW_AW-1:0]          w_rd_row;
  logic                         r_rd_v;
  logic [C_RATIO*C_MIN_W-1:0]   w_q_all;
  logic [READ_WIDTH-1:0]        w_rd_word;

  assign init_done  = (r_state == READY);
  assign w_clearing = (r_state == CLEAR) && (INIT_ZERO != 0);
  assign w_rd_acc   = r_valid && init_done;
  assign w_wr_acc   = w_valid && init_done;
  assign w_clr_row  = C_ROW_AW'(r_clr_cnt >> C_LOG_R);
  assign w_clr_lane = (C_RATIO > 1) ? C_LANE_W'(r_clr_cnt) : '0;
  assign w_wr_row   = C_ROW_AW'(w_addr >> C_W_SHIFT);
  assign w_rd_row   = C_ROW_AW'(r_addr >> C_R_SHIFT);

  // Init FSM state register; reset always restarts the clear from entry 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= CLEAR;
    else      r_state <= w_state_nxt;
  end

  // Next-state: leave CLEAR after the last narrow entry (or at once without zero-fill)
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CLEAR: if ((INIT_ZERO == 0) || (r_clr_cnt == C_NARROW_AW'(C_MAX_SIZE - 1))) w_state_nxt = READY;
      READY: w_state_nxt = READY;
    endcase
  end

  // Clear counter walks narrow entries one per cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            r_clr_cnt <= '0;
    else if (w_clearing) r_clr_cnt <= r_clr_cnt + C_NARROW_AW'(1);
  end

  // Read strobe tracks accepted reads through the memory stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rd_v <= 1'b0;
    else      r_rd_v <= w_rd_acc;
  end

  for (genvar gi = 0; gi < C_RATIO; gi++) begin : g_bank
    logic [C_MIN_W-1:0]  r_mem [C_ROWS];
    logic [C_MIN_W-1:0]  r_q;
    logic                w_hit;
    logic [C_BPL-1:0]    w_ube;
    logic [C_MIN_W-1:0]  w_uwd;
    logic                w_we;
    logic [C_ROW_AW-1:0] w_row;
    logic [C_BPL-1:0]    w_bev;
    logic [C_MIN_W-1:0]  w_wdv;

    if (C_WR_NARROW) begin : g_wnarrow
      assign w_hit = (C_LANE_W'(w_addr) == C_LANE_W'(gi));
      assign w_ube = w_be;
      assign w_uwd = w_data;
    end else begin : g_wwide
      assign w_hit = 1'b1;
      assign w_ube = w_be[gi*C_BPL +: C_BPL];
      assign w_uwd = w_data[gi*C_MIN_W +: C_MIN_W];
    end

    // Clear sequencer owns the write port until the block is ready
    assign w_we  = w_clearing ? (w_clr_lane == C_LANE_W'(gi)) : (w_wr_acc && w_hit);
    assign w_row = w_clearing ? w_clr_row : w_wr_row;
    assign w_bev = w_clearing ? '1 : w_ube;
    assign w_wdv = w_clearing ? '0 : w_uwd;

    // Byte-lane writes into this bank
    always_ff @(posedge clk) begin
      for (int b = 0; b < C_BPL; b++) begin
        if (w_we && w_bev[b]) r_mem[w_row][b*8 +: 8] <= w_wdv[b*8 +: 8];
      end
    end

    // Synchronous read-first port; holds its value when no read is accepted
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)          r_q <= '0;
      else if (w_rd_acc) r_q <= r_mem[w_rd_row];
    end

    assign w_q_all[gi*C_MIN_W +: C_MIN_W] = r_q;
  end

  if (C_RD_NARROW) begin : g_rnarrow
    logic [C_LANE_W-1:0] r_rd_lane;

    // Remember which bank the narrow read addressed
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)          r_rd_lane <= '0;
      else if (w_rd_acc) r_rd_lane <= C_LANE_W'(r_addr);
    end

    assign w_rd_word = w_q_all[r_rd_lane*C_MIN_W +: C_MIN_W];
  end else begin : g_rwide
    assign w_rd_word = w_q_all;
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [READ_WIDTH-1:0] r_dout;
    logic                  r_dout_v;

    // Extra pipeline stage on the read path
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_dout   <= '0;
        r_dout_v <= 1'b0;
      end else begin
        r_dout_v <= r_rd_v;
        if (r_rd_v) r_dout <= w_rd_word;
      end
    end

    assign r_data       = r_dout;
    assign r_data_valid = r_dout_v;
  end else begin : g_ocomb
    assign r_data       = w_rd_word;
    assign r_data_valid = r_rd_v;
  end

endmodule
`default_nettype wire

// File: tb/tb_bram_asym_be.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_asym_be
// Purpose  : Scoreboard bench for bram_asym_be in read-wider (default) and
//            write-wider (OUT_REG=1) configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_asym_be;

  typedef struct {
    logic [63:0] d;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_mis = 0;

  // read-wider instance (defaults)
  logic        init_done_a;
  logic        r_valid_a = 1'b0;
  logic [8:0]  r_addr_a = '0;
  logic [63:0] r_data_a;
  logic        r_data_valid_a;
  logic        w_valid_a = 1'b0;
  logic [9:0]  w_addr_a = '0;
  logic [31:0] w_data_a = '0;
  logic [3:0]  w_be_a = '0;

  // write-wider instance
  logic        init_done_b;
  logic        r_valid_b = 1'b0;
  logic [9:0]  r_addr_b = '0;
  logic [31:0] r_data_b;
  logic        r_data_valid_b;
  logic        w_valid_b = 1'b0;
  logic [8:0]  w_addr_b = '0;
  logic [63:0] w_data_b = '0;
  logic [7:0]  w_be_b = '0;

  logic [31:0] mdl_a [1024];
  logic [31:0] mdl_b [1024];
  exp_t        q_a [$];
  exp_t        q_b [$];
  logic [63:0] last_a = '0;
  logic [63:0] last_b = '0;

  bram_asym_be dut_a (
    .clk(clk), .rst(rst), .init_done(init_done_a),
    .r_valid(r_valid_a), .r_addr(r_addr_a), .r_data(r_data_a), .r_data_valid(r_data_valid_a),
    .w_valid(w_valid_a), .w_addr(w_addr_a), .w_data(w_data_a), .w_be(w_be_a)
  );

  bram_asym_be #(
    .READ_WIDTH(32), .READ_ADDR_WIDTH(10), .WRITE_WIDTH(64), .WRITE_ADDR_WIDTH(9),
    .OUT_REG(1), .INIT_ZERO(1)
  ) dut_b (
    .clk(clk), .rst(rst), .init_done(init_done_b),
    .r_valid(r_valid_b), .r_addr(r_addr_b), .r_data(r_data_b), .r_data_valid(r_data_valid_b),
    .w_valid(w_valid_b), .w_addr(w_addr_b), .w_data(w_data_b), .w_be(w_be_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_mis++;
      $display("FAIL %s: actual=%h expected=%h (cycle %0d)", tag, act, exp_v, cyc);
    end
  endtask

  // Scoreboard for instance A: valid must match the due schedule every cycle
  always @(posedge clk) begin
    exp_t e;
    bit   ev;
    #1;
    ev = (q_a.size() > 0) && (q_a[0].due == cyc);
    chk("a_valid", {63'd0, r_data_valid_a}, {63'd0, ev});
    if (ev) begin
      e = q_a.pop_front();
      chk("a_data", r_data_a, e.d);
      last_a = e.d;
    end else if ((q_a.size() > 0) && (q_a[0].due < cyc)) begin
      e = q_a.pop_front();
      chk("a_late", 64'(cyc), 64'(e.due));
    end
  end

  // Scoreboard for instance B
  always @(posedge clk) begin
    exp_t e;
    bit   ev;
    #1;
    ev = (q_b.size() > 0) && (q_b[0].due == cyc);
    chk("b_valid", {63'd0, r_data_valid_b}, {63'd0, ev});
    if (ev) begin
      e = q_b.pop_front();
      chk("b_data", {32'd0, r_data_b}, e.d);
      last_b = e.d;
    end else if ((q_b.size() > 0) && (q_b[0].due < cyc)) begin
      e = q_b.pop_front();
      chk("b_late", 64'(cyc), 64'(e.due));
    end
  end

  task automatic zero_models();
    for (int i = 0; i < 1024; i++) begin
      mdl_a[i] = '0;
      mdl_b[i] = '0;
    end
  endtask

  // One cycle on port A; read expectation taken before the write lands (read-first)
  task automatic step_a(input bit wv, input logic [9:0] wa, input logic [31:0] wd,
                        input logic [3:0] wbe, input bit rv, input logic [8:0] ra);
    exp_t e;
    w_valid_a = wv; w_addr_a = wa; w_data_a = wd; w_be_a = wbe;
    r_valid_a = rv; r_addr_a = ra;
    if (rv) begin
      e.d   = {mdl_a[2*ra+1], mdl_a[2*ra]};
      e.due = cyc + 1;
      q_a.push_back(e);
    end
    if (wv) for (int k = 0; k < 4; k++) if (wbe[k]) mdl_a[wa][8*k +: 8] = wd[8*k +: 8];
    @(negedge clk);
    w_valid_a = 1'b0; r_valid_a = 1'b0;
  endtask

  task automatic step_b(input bit wv, input logic [8:0] wa, input logic [63:0] wd,
                        input logic [7:0] wbe, input bit rv, input logic [9:0] ra);
    exp_t e;
    w_valid_b = wv; w_addr_b = wa; w_data_b = wd; w_be_b = wbe;
    r_valid_b = rv; r_addr_b = ra;
    if (rv) begin
      e.d   = {32'd0, mdl_b[ra]};
      e.due = cyc + 2;
      q_b.push_back(e);
    end
    if (wv) for (int k = 0; k < 8; k++) if (wbe[k]) mdl_b[2*wa + k/4][8*(k%4) +: 8] = wd[8*k +: 8];
    @(negedge clk);
    w_valid_b = 1'b0; r_valid_b = 1'b0;
  endtask

  // Counts edges after release until init_done_a is seen, bounded
  task automatic count_init(output int n);
    n = 0;
    while (n < 3000) begin
      @(posedge clk);
      #1;
      n++;
      if (init_done_a) break;
    end
  endtask

  initial begin
    int n;
    zero_models();

    repeat (3) @(negedge clk);
    chk("rst_r_data_a", r_data_a, 64'd0);
    chk("rst_r_data_b", {32'd0, r_data_b}, 64'd0);
    chk("rst_init_done_a", {63'd0, init_done_a}, 64'd0);
    chk("rst_init_done_b", {63'd0, init_done_b}, 64'd0);

    rst = 1'b1;
    count_init(n);
    chk("init_cycles", 64'(n), 64'd1024);
    chk("init_done_b", {63'd0, init_done_b}, 64'd1);
    @(negedge clk);

    // cleared contents, back-to-back reads
    step_a(0, 10'd0, 32'd0, 4'h0, 1, 9'd7);
    step_a(0, 10'd0, 32'd0, 4'h0, 1, 9'd0);
    // two narrow writes gathered by one wide read
    step_a(1, 10'd10, 32'hDDCCBBAA, 4'hF, 0, 9'd0);
    step_a(1, 10'd11, 32'h44332211, 4'hF, 0, 9'd0);
    step_a(0, 10'd0, 32'd0, 4'h0, 1, 9'd5);
    // single byte enable
    step_a(1, 10'd10, 32'h00EE0000, 4'b0100, 0, 9'd0);
    step_a(0, 10'd0, 32'd0, 4'h0, 1, 9'd5);
    // collision: old data, then new data on the following read
    step_a(1, 10'd10, 32'h12345678, 4'hF, 1, 9'd5);
    step_a(0, 10'd0, 32'd0, 4'h0, 1, 9'd5);
    // all byte enables low is a no-op
    step_a(1, 10'd11, 32'hFFFFFFFF, 4'h0, 1, 9'd5);
    step_a(0, 10'd0, 32'd0, 4'h0, 1, 9'd5);
    // disjoint simultaneous write and read
    step_a(1, 10'd0, 32'hCAFEF00D, 4'hF, 1, 9'd5);
    step_a(0, 10'd0, 32'd0, 4'h0, 1, 9'd0);
    // top of the address space
    step_a(1, 10'd1023, 32'hA5A5A5A5, 4'hF, 0, 9'd0);
    step_a(1, 10'd1022, 32'h5A5A5A5A, 4'hF, 1, 9'd511);
    step_a(0, 10'd0, 32'd0, 4'h0, 1, 9'd511);
    // mixed traffic in a small window
    for (int i = 0; i < 40; i++)
      step_a(1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom, 4'($urandom),
             1'($urandom_range(0, 1)), 9'($urandom_range(0, 7)));
    repeat (4) @(negedge clk);
    chk("a_hold", r_data_a, last_a);

    // write-wider: one wide write scattered over two narrow entries
    step_b(1, 9'd3, 64'h01234567_89ABCDEF, 8'hFF, 0, 10'd0);
    step_b(0, 9'd0, 64'd0, 8'h00, 1, 10'd6);
    step_b(0, 9'd0, 64'd0, 8'h00, 1, 10'd7);
    step_b(1, 9'd3, 64'hFFFFFFFF_FFFFFFFF, 8'h81, 1, 10'd7);
    step_b(0, 9'd0, 64'd0, 8'h00, 1, 10'd6);
    step_b(0, 9'd0, 64'd0, 8'h00, 1, 10'd7);
    for (int i = 0; i < 30; i++)
      step_b(1'($urandom_range(0, 1)), 9'($urandom_range(0, 7)), {$urandom, $urandom}, 8'($urandom),
             1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)));
    repeat (5) @(negedge clk);
    chk("b_hold", {32'd0, r_data_b}, last_b);

    // reset, then abort the clear part-way through
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst2_r_data_a", r_data_a, 64'd0);
    rst = 1'b1;
    repeat (500) @(negedge clk);
    chk("mid_init_done", {63'd0, init_done_a}, 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    r_valid_a = 1'b1; r_addr_a = 9'd5;
    r_valid_b = 1'b1; r_addr_b = 10'd6;
    count_init(n);
    r_valid_a = 1'b0; r_valid_b = 1'b0;
    chk("reclear_cycles", 64'(n), 64'd1024);
    zero_models();
    @(negedge clk);
    step_a(0, 10'd0, 32'd0, 4'h0, 1, 9'd5);
    step_a(0, 10'd0, 32'd0, 4'h0, 1, 9'd511);
    step_b(0, 9'd0, 64'd0, 8'h00, 1, 10'd6);
    step_b(0, 9'd0, 64'd0, 8'h00, 1, 10'd7);
    repeat (5) @(negedge clk);

    chk("a_drained", 64'(q_a.size()), 64'd0);
    chk("b_drained", 64'(q_b.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bram_asym_be.md
Name: bram_asym_be

Overview:
- Next-generation asymmetric simple-dual-port block RAM for instruction/data buffers.
- Supports both read-wider and write-wider aspect ratios, per-byte write enables, an optional output register and a read-valid strobe.
- Optionally zero-fills its contents after reset using an internal sequencer.
- Drop-in for M9K-backed buffers that are loaded narrow over a host bus and read wide by cores, or the reverse.

Parameters:
- READ_WIDTH, 64, read port data width in bits.
- READ_ADDR_WIDTH, 9, read port address width; read depth = 2**READ_ADDR_WIDTH.
- WRITE_WIDTH, 32, write port data width in bits; must be a multiple of 8.
- WRITE_ADDR_WIDTH, 10, write port address width; write depth = 2**WRITE_ADDR_WIDTH.
- OUT_REG, 0, 1 adds an output pipeline register (read latency 2 instead of 1).
- INIT_ZERO, 1, 1 clears every entry after reset before accepting traffic.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- init_done  out  1  high when the block accepts reads and writes.
- r_valid  in  1  read request.
- r_addr  in  READ_ADDR_WIDTH  read address.
- r_data  out  READ_WIDTH  read data.
- r_data_valid  out  1  one-cycle strobe marking r_data as new.
- w_valid  in  1  write request.
- w_addr  in  WRITE_ADDR_WIDTH  write address.
- w_data  in  WRITE_WIDTH  write data.
- w_be  in  WRITE_WIDTH/8  byte enables; bit k covers w_data[8k+7:8k].

Behaviour:
- Geometry:
  - minW = min(READ_WIDTH, WRITE_WIDTH), maxW = max(...), RATIO = maxW/minW.
  - RATIO must be a power of two, and READ_WIDTH*2**READ_ADDR_WIDTH == WRITE_WIDTH*2**WRITE_ADDR_WIDTH.
  - Violations are reported as an elaboration error.
  - Storage is maxSIZE entries of minW bits, inferred as M9K.
- Lane mapping, little-endian: wide word at address A, lane i (bits [(i+1)*minW-1 : i*minW]) maps to narrow entry {A, i}.
  - Read-wider: one read gathers RATIO entries.
  - Write-wider: one write scatters RATIO entries in the same cycle.
- Byte enables: only bytes with w_be=1 are modified; w_be=0 leaves the entry untouched. w_valid with all w_be=0 is a no-op.
- Reset (rst=0, async):
  - r_data=0, r_data_valid=0, init_done=0, clear counter=0.
  - Memory contents are not reset by rst itself.
- Init FSM, states CLEAR, READY:
  - INIT_ZERO=1: after rst release, enter CLEAR and write 0 to one narrow entry per cycle, counter 0..maxSIZE-1. After the last entry, move to READY and raise init_done on the next edge. Total: maxSIZE cycles.
  - INIT_ZERO=0: enter READY; init_done rises on the first clk edge after release.
  - rst asserted mid-CLEAR: aborts; the clear restarts from entry 0 on release.
- Requests while init_done=0 are ignored: no write, no r_data_valid.
- Read latency:
  - OUT_REG=0: r_data and r_data_valid update on the edge following the accepting edge (1 cycle).
  - OUT_REG=1: 2 cycles.
  - r_data holds its last value when no read completes; r_data_valid is 1 only in the cycle data is new.
  - Back-to-back reads are fully pipelined: one result per cycle.
- Read/write collision: same cycle and overlapping entries is read-first (old data returned). A read accepted the cycle after a write returns the new data.
- Simultaneous r_valid and w_valid to disjoint entries: both complete, with no stall.
- No backpressure: the read port has no ready signal; the consumer must accept every r_data_valid.

Test Plan:
- Defaults, INIT_ZERO=1: release rst, count cycles -> init_done rises after 1024 cycles; a read of any address then returns 0x0.
- Defaults: write 0xDDCCBBAA @10 and 0x44332211 @11 (w_be=4'hF); read r_addr=5 -> r_data=0x44332211_DDCCBBAA one cycle later, r_data_valid high for exactly 1 cycle.
- Byte enables: after the previous test, write 0x00EE0000 @10 with w_be=4'b0100; read 5 -> r_data=0x44332211_DDEEBBAA.
- Collision: same cycle, write 0x12345678 @10 and read 5 -> old 0x44332211_DDEEBBAA; read 5 on the next cycle -> 0x44332211_12345678.
- Write-wider (READ_WIDTH=32, READ_ADDR_WIDTH=10, WRITE_WIDTH=64, WRITE_ADDR_WIDTH=9, OUT_REG=1): write 0x01234567_89ABCDEF @3 -> read 6 gives 0x89ABCDEF and read 7 gives 0x01234567, each 2 cycles after the request.
- Reset mid-clear: assert rst at clear cycle 500, release -> init_done low for a full 1024 cycles; an r_valid issued during the clear produces no r_data_valid.
